// File: rtl/color_pkg.sv
// Shared colour codes and stabilizer state encoding used by the detector,
// the result stabilizer and the game FSM.
package color_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        RED   = 2'b01,
        GREEN = 2'b10,
        BLUE  = 2'b11
    } color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        HOLD  = 2'b10,
        CLEAR = 2'b11
    } stab_state_t;

    localparam color_t COLOR_NONE  = NONE;
    localparam color_t COLOR_RED   = RED;
    localparam color_t COLOR_GREEN = GREEN;
    localparam color_t COLOR_BLUE  = BLUE;

endpackage

// File: rtl/color_result_stabilizer.sv
// Locks a dice colour after STABLE_FRAMES consecutive confident frames and
// holds it under a valid/ack handshake. Option STAB_REQUIRE_CLEAR_EN adds CLEAR.
module color_result_stabilizer
    import color_pkg::*;
#(
    parameter int          STABLE_FRAMES  = 4,
    parameter logic [15:0] MIN_CONFIDENCE = 16'd200,
    parameter int          TIMEOUT_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        color_valid,
    input  logic [1:0]  dominant_color,
    input  logic [15:0] color_confidence,
    output logic        busy,
    output logic        result_valid,
    output logic [1:0]  result_color,
    output logic [15:0] result_confidence,
    input  logic        result_ack,
    output logic        timeout
);

    localparam int RW = $clog2(STABLE_FRAMES + 1);
    localparam int FW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [RW-1:0] RUN_TARGET  = RW'(STABLE_FRAMES);
    localparam logic [FW-1:0] FRAME_LIMIT = FW'(TIMEOUT_FRAMES);

    stab_state_t   state, state_n;
    logic [RW-1:0] run_count, run_count_n;
    logic [FW-1:0] frame_count, frame_count_n, frame_next;
    color_t        candidate, candidate_n;
    logic [15:0]   run_min, run_min_n;
    logic          result_valid_n, timeout_n;
    logic [1:0]    result_color_n;
    logic [15:0]   result_confidence_n;
    logic          qualifying;
    color_t        frame_color;

    assign frame_color = color_t'(dominant_color);
    assign qualifying  = color_valid && (frame_color != COLOR_NONE)
                         && (color_confidence >= MIN_CONFIDENCE);
    assign frame_next  = (frame_count == FRAME_LIMIT) ? frame_count : frame_count + 1'b1;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            run_count         <= '0;
            frame_count       <= '0;
            candidate         <= COLOR_NONE;
            run_min           <= '0;
            result_valid      <= 1'b0;
            result_color      <= 2'b00;
            result_confidence <= '0;
            timeout           <= 1'b0;
        end else begin
            state             <= state_n;
            run_count         <= run_count_n;
            frame_count       <= frame_count_n;
            candidate         <= candidate_n;
            run_min           <= run_min_n;
            result_valid      <= result_valid_n;
            result_color      <= result_color_n;
            result_confidence <= result_confidence_n;
            timeout           <= timeout_n;
        end
    end

    always_comb begin
        state_n             = state;
        run_count_n         = run_count;
        frame_count_n       = frame_count;
        candidate_n         = candidate;
        run_min_n           = run_min;
        result_valid_n      = result_valid;
        result_color_n      = result_color;
        result_confidence_n = result_confidence;
        timeout_n           = 1'b0;

        case (state)
            IDLE: begin
                if (arm) begin
`ifdef STAB_REQUIRE_CLEAR_EN
                    state_n = CLEAR;
`else
                    state_n = TRACK;
`endif
                    run_count_n   = '0;
                    frame_count_n = '0;
                    candidate_n   = COLOR_NONE;
                    run_min_n     = '0;
                end
            end
            TRACK: begin
                if (color_valid) begin
                    frame_count_n = frame_next;
                    if (qualifying) begin
                        if (frame_color == candidate) begin
                            run_count_n = (run_count == RUN_TARGET) ? run_count : run_count + 1'b1;
                            run_min_n   = (color_confidence < run_min) ? color_confidence : run_min;
                        end else begin
                            candidate_n = frame_color;
                            run_count_n = RW'(1);
                            run_min_n   = color_confidence;
                        end
                    end else begin
                        run_count_n = '0;
                        candidate_n = COLOR_NONE;
                    end
                    // A lock on the final allowed frame takes priority over timeout.
                    if (run_count_n == RUN_TARGET) begin
                        state_n             = HOLD;
                        result_valid_n      = 1'b1;
                        result_color_n      = candidate_n;
                        result_confidence_n = run_min_n;
                    end else if (frame_count_n == FRAME_LIMIT) begin
                        timeout_n = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            HOLD: begin
                if (result_ack) begin
                    result_valid_n = 1'b0;
                    state_n        = IDLE;
                end
            end
`ifdef STAB_REQUIRE_CLEAR_EN
            CLEAR: begin
                if (color_valid) begin
                    frame_count_n = frame_next;
                    if (frame_next == FRAME_LIMIT) begin
                        timeout_n = 1'b1;
                        state_n   = IDLE;
                    end else if (!qualifying) begin
                        state_n = TRACK;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_color_result_stabilizer.sv
// Directed self-checking bench for color_result_stabilizer with a result scoreboard;
// instances cover default, short-timeout, lock-vs-timeout and single-frame-lock builds.
`timescale 1ns/1ps
module tb_color_result_stabilizer;
    import color_pkg::*;

    typedef struct {
        logic [1:0]  color;
        logic [15:0] conf;
    } exp_t;

`ifdef STAB_REQUIRE_CLEAR_EN
    localparam int CLR_FRAMES = 1;
`else
    localparam int CLR_FRAMES = 0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  arm_bus;
    logic        color_valid;
    logic [1:0]  dominant_color;
    logic [15:0] color_confidence;
    logic        result_ack;
    logic [3:0]  busy_v;
    logic [3:0]  rv_v;
    logic [3:0]  to_v;
    logic [1:0]  rc_v [4];
    logic [15:0] rconf_v [4];

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];
    logic rv_prev = 1'b0;

    color_result_stabilizer dut (
        .clk(clk), .reset(reset), .arm(arm_bus[0]), .color_valid(color_valid),
        .dominant_color(dominant_color), .color_confidence(color_confidence),
        .busy(busy_v[0]), .result_valid(rv_v[0]), .result_color(rc_v[0]),
        .result_confidence(rconf_v[0]), .result_ack(result_ack), .timeout(to_v[0]));

    color_result_stabilizer #(.TIMEOUT_FRAMES(5)) dut_t5 (
        .clk(clk), .reset(reset), .arm(arm_bus[1]), .color_valid(color_valid),
        .dominant_color(dominant_color), .color_confidence(color_confidence),
        .busy(busy_v[1]), .result_valid(rv_v[1]), .result_color(rc_v[1]),
        .result_confidence(rconf_v[1]), .result_ack(result_ack), .timeout(to_v[1]));

    color_result_stabilizer #(.STABLE_FRAMES(4), .TIMEOUT_FRAMES(4)) dut_t4 (
        .clk(clk), .reset(reset), .arm(arm_bus[2]), .color_valid(color_valid),
        .dominant_color(dominant_color), .color_confidence(color_confidence),
        .busy(busy_v[2]), .result_valid(rv_v[2]), .result_color(rc_v[2]),
        .result_confidence(rconf_v[2]), .result_ack(result_ack), .timeout(to_v[2]));

    color_result_stabilizer #(.STABLE_FRAMES(1)) dut_s1 (
        .clk(clk), .reset(reset), .arm(arm_bus[3]), .color_valid(color_valid),
        .dominant_color(dominant_color), .color_confidence(color_confidence),
        .busy(busy_v[3]), .result_valid(rv_v[3]), .result_color(rc_v[3]),
        .result_confidence(rconf_v[3]), .result_ack(result_ack), .timeout(to_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=expired required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard whenever the main instance raises result_valid.
    always @(negedge clk) begin
        if (reset) begin
            rv_prev = 1'b0;
        end else begin
            if (rv_v[0] && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("sb_color", 32'(rc_v[0]), 32'(e.color));
                    check_output("sb_conf", 32'(rconf_v[0]), 32'(e.conf));
                end
            end
            rv_prev = rv_v[0];
        end
    end

    task automatic apply_stimulus(input logic [1:0] c, input logic [15:0] conf);
        @(posedge clk); #1;
        color_valid      = 1'b1;
        dominant_color   = c;
        color_confidence = conf;
        @(posedge clk); #1;
        color_valid = 1'b0;
    endtask

    task automatic raw_arm(input int idx);
        @(posedge clk); #1;
        arm_bus[idx] = 1'b1;
        @(posedge clk); #1;
        arm_bus = '0;
    endtask

    task automatic do_arm(input int idx);
        raw_arm(idx);
`ifdef STAB_REQUIRE_CLEAR_EN
        apply_stimulus(2'b00, 16'd0);
`endif
    endtask

    task automatic do_ack();
        @(posedge clk); #1;
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        arm_bus = '0;
        color_valid = 1'b0;
        dominant_color = 2'b00;
        color_confidence = '0;
        result_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", 32'(busy_v[0]), 32'd0);
        check_output("rst_valid", 32'(rv_v[0]), 32'd0);
        check_output("rst_color", 32'(rc_v[0]), 32'd0);
        check_output("rst_conf", 32'(rconf_v[0]), 32'd0);
        check_output("rst_timeout", 32'(to_v[0]), 32'd0);
        reset = 1'b0;

        $display("[TB] test 1: RED run with min confidence");
        do_arm(0);
        check_output("t1_busy_armed", 32'(busy_v[0]), 32'd1);
        exp_q.push_back('{color: 2'b01, conf: 16'd300});
        apply_stimulus(2'b01, 16'd500);
        apply_stimulus(2'b01, 16'd300);
        apply_stimulus(2'b01, 16'd450);
        check_output("t1_no_early_lock", 32'(rv_v[0]), 32'd0);
        apply_stimulus(2'b01, 16'd600);
        check_output("t1_valid", 32'(rv_v[0]), 32'd1);
        check_output("t1_color", 32'(rc_v[0]), 32'd1);
        check_output("t1_conf", 32'(rconf_v[0]), 32'd300);
        check_output("t1_busy_hold", 32'(busy_v[0]), 32'd1);
        apply_stimulus(2'b10, 16'd999);
        check_output("t1_hold_stable", 32'(rc_v[0]), 32'd1);
        do_ack();
        check_output("t1_ack_valid", 32'(rv_v[0]), 32'd0);
        check_output("t1_ack_busy", 32'(busy_v[0]), 32'd0);
        check_output("t1_color_kept", 32'(rc_v[0]), 32'd1);

        $display("[TB] test 2: colour change restarts run");
        do_arm(0);
        exp_q.push_back('{color: 2'b11, conf: 16'd400});
        apply_stimulus(2'b10, 16'd400);
        apply_stimulus(2'b10, 16'd400);
        apply_stimulus(2'b11, 16'd400);
        apply_stimulus(2'b11, 16'd400);
        apply_stimulus(2'b11, 16'd400);
        check_output("t2_no_lock5", 32'(rv_v[0]), 32'd0);
        apply_stimulus(2'b11, 16'd400);
        check_output("t2_valid", 32'(rv_v[0]), 32'd1);
        check_output("t2_color", 32'(rc_v[0]), 32'd3);
        do_ack();

        $display("[TB] test 3: low confidence frame breaks run");
        do_arm(0);
        exp_q.push_back('{color: 2'b01, conf: 16'd500});
        apply_stimulus(2'b01, 16'd500);
        apply_stimulus(2'b01, 16'd150);
        apply_stimulus(2'b01, 16'd500);
        apply_stimulus(2'b01, 16'd500);
        apply_stimulus(2'b01, 16'd500);
        check_output("t3_no_lock5", 32'(rv_v[0]), 32'd0);
        apply_stimulus(2'b01, 16'd500);
        check_output("t3_valid", 32'(rv_v[0]), 32'd1);
        check_output("t3_conf", 32'(rconf_v[0]), 32'd500);
        do_ack();

        $display("[TB] test 4: timeout after five frames");
        do_arm(1);
        for (int i = 0; i < 4 - CLR_FRAMES; i++) apply_stimulus(2'b00, 16'd0);
        check_output("t4_no_early_timeout", 32'(to_v[1]), 32'd0);
        apply_stimulus(2'b00, 16'd0);
        check_output("t4_timeout", 32'(to_v[1]), 32'd1);
        check_output("t4_idle", 32'(busy_v[1]), 32'd0);
        @(posedge clk); #1;
        check_output("t4_timeout_pulse", 32'(to_v[1]), 32'd0);
        check_output("t4_no_result", 32'(rv_v[1]), 32'd0);

`ifndef STAB_REQUIRE_CLEAR_EN
        $display("[TB] test 5: lock wins over timeout on same frame");
        do_arm(2);
        for (int i = 0; i < 4; i++) apply_stimulus(2'b11, 16'd300);
        check_output("t5_lock", 32'(rv_v[2]), 32'd1);
        check_output("t5_no_timeout", 32'(to_v[2]), 32'd0);
        do_ack();
        check_output("t5_no_timeout_late", 32'(to_v[2]), 32'd0);
`endif

        $display("[TB] test 6: single-frame lock at threshold");
        do_arm(3);
        apply_stimulus(2'b01, 16'd199);
        check_output("t6_below_min", 32'(rv_v[3]), 32'd0);
        apply_stimulus(2'b10, 16'd200);
        check_output("t6_lock", 32'(rv_v[3]), 32'd1);
        check_output("t6_color", 32'(rc_v[3]), 32'd2);
        check_output("t6_conf", 32'(rconf_v[3]), 32'd200);
        do_ack();

        $display("[TB] test 7: reset in HOLD");
        do_arm(0);
        exp_q.push_back('{color: 2'b01, conf: 16'd250});
        for (int i = 0; i < 4; i++) apply_stimulus(2'b01, 16'd250);
        check_output("t7_lock", 32'(rv_v[0]), 32'd1);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check_output("t7_rst_valid", 32'(rv_v[0]), 32'd0);
        check_output("t7_rst_busy", 32'(busy_v[0]), 32'd0);
        check_output("t7_rst_color", 32'(rc_v[0]), 32'd0);
        check_output("t7_rst_conf", 32'(rconf_v[0]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

`ifdef STAB_REQUIRE_CLEAR_EN
        $display("[TB] test 8: clear frame required before tracking");
        raw_arm(0);
        exp_q.push_back('{color: 2'b01, conf: 16'd500});
        for (int i = 0; i < 4; i++) apply_stimulus(2'b01, 16'd500);
        check_output("t8_no_lock", 32'(rv_v[0]), 32'd0);
        apply_stimulus(2'b00, 16'd0);
        for (int i = 0; i < 3; i++) apply_stimulus(2'b01, 16'd500);
        check_output("t8_no_early_lock", 32'(rv_v[0]), 32'd0);
        apply_stimulus(2'b01, 16'd500);
        check_output("t8_lock", 32'(rv_v[0]), 32'd1);
        do_ack();
`endif

        @(posedge clk); #1;
        check_output("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
